// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : Register map, CTRL layout and shared types for machine_timer.
// Revision : 1.0
// ============================================================================
package timer_pkg;

  localparam int unsigned CTRL_DIV_W = 8;

  localparam logic [4:0] MTIME_LO_OFF = 5'h00;
  localparam logic [4:0] MTIME_HI_OFF = 5'h04;
  localparam logic [4:0] CMP_LO_OFF   = 5'h08;
  localparam logic [4:0] CMP_HI_OFF   = 5'h0C;
  localparam logic [4:0] CTRL_OFF     = 5'h10;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_DIV_LSB = 1;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [CTRL_DIV_W-1:0] div;
    logic                  en;
  } ctrl_t;

  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/machine_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : machine_timer_if
// Brief    : Data-memory bus between the core and the machine timer.
// Revision : 1.0
// ============================================================================
interface machine_timer_if #(
  parameter int unsigned XLEN = 32
);
  logic            bus_valid;
  logic            bus_ready;
  logic            bus_we;
  logic [4:0]      bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [XLEN-1:0] bus_rdata;
  logic            bus_rvalid;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rdata, bus_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : timer_prescaler
// Brief    : Counts 0..div while enabled and emits one tick per wrap.
// Revision : 1.0
// ============================================================================
module timer_prescaler #(
  parameter int unsigned DIV_W = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             en_i,
  input  wire logic [DIV_W-1:0] div_i,
  input  wire logic             clr_i,
  output logic                  tick_o
);

  logic [DIV_W-1:0] pcnt_q;

  // A CTRL write restarts the count, so it also swallows a tick due that cycle.
  assign tick_o = en_i & ~clr_i & (pcnt_q == div_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
    end else if (clr_i || tick_o) begin
      pcnt_q <= '0;
    end else if (en_i) begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/machine_timer.sv
`default_nettype none
// ============================================================================
// Module   : machine_timer
// Brief    : Memory-mapped mtime/mtimecmp with prescaler, driving MTI.
// Revision : 1.0
// ============================================================================
module machine_timer
  import timer_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DIV_W = CTRL_DIV_W
) (
  input  wire logic      clk,
  input  wire logic      reset,
  machine_timer_if.slave bus,
  output logic           MTI
);

  localparam int unsigned TW = 2 * XLEN;

  bus_state_t      state_q, state_d;
  logic [TW-1:0]   mtime_q, mtime_d;
  logic [TW-1:0]   cmp_q, cmp_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] shadow_q, shadow_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mti_q;

  logic [4:0]      w_addr;
  logic            w_acc, w_wr, w_rd, w_wr_ctrl, w_tick;
  logic            w_ready, w_rvalid;

  assign w_addr    = bus.bus_addr & 5'b11100;
  assign w_acc     = bus.bus_valid & (state_q == BUS_IDLE);
  assign w_wr      = w_acc & bus.bus_we;
  assign w_rd      = w_acc & ~bus.bus_we;
  assign w_wr_ctrl = w_wr & (w_addr == CTRL_OFF);

  timer_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en_i   (ctrl_q.en),
    .div_i  (ctrl_q.div),
    .clr_i  (w_wr_ctrl),
    .tick_o (w_tick)
  );

  always_comb begin
    state_d  = state_q;
    w_ready  = 1'b0;
    w_rvalid = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        w_ready = 1'b1;
        if (bus.bus_valid && !bus.bus_we) state_d = BUS_RESP;
      end
      BUS_RESP: begin
        w_rvalid = 1'b1;
        state_d  = BUS_IDLE;
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    mtime_d  = mtime_q + TW'(w_tick);
    cmp_d    = cmp_q;
    ctrl_d   = ctrl_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    // A software write to either mtime half overrides that cycle's tick entirely.
    if (w_wr) begin
      case (w_addr)
        MTIME_LO_OFF: mtime_d = {mtime_q[TW-1:XLEN], bus.bus_wdata};
        MTIME_HI_OFF: mtime_d = {bus.bus_wdata, mtime_q[XLEN-1:0]};
        CMP_LO_OFF:   cmp_d   = {cmp_q[TW-1:XLEN], bus.bus_wdata};
        CMP_HI_OFF:   cmp_d   = {bus.bus_wdata, cmp_q[XLEN-1:0]};
        CTRL_OFF: begin
          ctrl_d.en  = bus.bus_wdata[CTRL_EN_BIT];
          ctrl_d.div = bus.bus_wdata[CTRL_DIV_LSB +: CTRL_DIV_W];
        end
        default: ;
      endcase
    end
    if (w_rd) begin
      case (w_addr)
        MTIME_LO_OFF: begin
          rdata_d  = mtime_q[XLEN-1:0];
          shadow_d = mtime_q[TW-1:XLEN];
        end
        MTIME_HI_OFF: rdata_d = shadow_q;
        CMP_LO_OFF:   rdata_d = cmp_q[XLEN-1:0];
        CMP_HI_OFF:   rdata_d = cmp_q[TW-1:XLEN];
        CTRL_OFF:     rdata_d = XLEN'(ctrl_q);
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= BUS_IDLE;
      mtime_q  <= '0;
      cmp_q    <= TW'(MTIMECMP_RST);
      ctrl_q   <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
      mti_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      ctrl_q   <= ctrl_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      mti_q    <= (mtime_q >= cmp_q);
    end
  end

  assign bus.bus_ready  = w_ready;
  assign bus.bus_rvalid = w_rvalid;
  assign bus.bus_rdata  = rdata_q;
  assign MTI            = mti_q;

endmodule
`default_nettype wire

// File: tb/tb_machine_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_machine_timer
// Brief    : Directed plus randomized bus traffic against a cycle reference model.
// Revision : 1.0
// ============================================================================
module tb_machine_timer;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic mti;

  machine_timer_if #(.XLEN(32)) bif ();

  machine_timer #(.XLEN(32), .DIV_W(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bif),
    .MTI   (mti)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_shadow, m_rdata;
  logic [7:0]  m_div;
  int          m_pcnt;
  bit          m_en, m_mti, m_resp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime = '0; m_cmp = '1; m_shadow = '0; m_rdata = '0;
    m_div = '0; m_pcnt = 0; m_en = 0; m_mti = 0; m_resp = 0;
  endtask

  task automatic model_step(input bit v, input bit we, input logic [4:0] addr, input logic [31:0] wd);
    logic [4:0] a;
    bit acc, wr_ctrl, mt_wr, tick, mti_n;
    a       = addr & 5'h1C;
    acc     = v && !m_resp;
    wr_ctrl = acc && we && (a == 5'h10);
    mt_wr   = acc && we && (a == 5'h00 || a == 5'h04);
    tick    = m_en && (m_pcnt == int'(m_div)) && !wr_ctrl;
    mti_n   = (m_mtime >= m_cmp);
    m_resp  = acc && !we;
    if (acc && !we) begin
      case (a)
        5'h00: begin m_rdata = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
        5'h04: m_rdata = m_shadow;
        5'h08: m_rdata = m_cmp[31:0];
        5'h0C: m_rdata = m_cmp[63:32];
        5'h10: m_rdata = {23'd0, m_div, m_en};
        default: m_rdata = 32'd0;
      endcase
    end
    if (tick) m_pcnt = 0;
    else if (m_en) m_pcnt = m_pcnt + 1;
    if (tick && !mt_wr) m_mtime = m_mtime + 64'd1;
    if (acc && we) begin
      case (a)
        5'h00: m_mtime[31:0]  = wd;
        5'h04: m_mtime[63:32] = wd;
        5'h08: m_cmp[31:0]    = wd;
        5'h0C: m_cmp[63:32]   = wd;
        5'h10: begin m_en = wd[0]; m_div = wd[8:1]; m_pcnt = 0; end
        default: ;
      endcase
    end
    m_mti = mti_n;
  endtask

  task automatic check_outputs();
    check_eq("mti", mti, m_mti);
    check_eq("ready", bif.bus_ready, !m_resp);
    check_eq("rvalid", bif.bus_rvalid, m_resp);
    if (m_resp) check_eq("rdata", bif.bus_rdata, m_rdata);
  endtask

  task automatic cycle(input bit v, input bit we, input logic [4:0] addr, input logic [31:0] wd);
    bif.bus_valid = v;
    bif.bus_we    = we;
    bif.bus_addr  = addr;
    bif.bus_wdata = wd;
    @(posedge clk);
    model_step(v, we, addr, wd);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'h00, 32'h0);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] wd);
    if (m_resp) idle(1);
    cycle(1'b1, 1'b1, addr, wd);
  endtask

  task automatic rd_expect(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    if (m_resp) idle(1);
    cycle(1'b1, 1'b0, addr, 32'h0);
    check_eq(tag, bif.bus_rdata, exp);
  endtask

  initial begin
    bit did_rst;
    logic [31:0] d;
    logic [4:0]  a;
    did_rst = 0;
    rst_n = 1'b1;
    bif.bus_valid = 1'b0; bif.bus_we = 1'b0; bif.bus_addr = '0; bif.bus_wdata = '0;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_mti", mti, 0);
      check_eq("rst_rvalid", bif.bus_rvalid, 0);
      check_eq("rst_rdata", bif.bus_rdata, 0);
      check_eq("rst_ready", bif.bus_ready, 1);
    end
    rst_n = 1'b1;

    // Reset values through the bus
    rd_expect("t1_cmp_lo", CMP_LO_OFF, 32'hFFFF_FFFF);
    rd_expect("t1_cmp_hi", CMP_HI_OFF, 32'hFFFF_FFFF);
    rd_expect("t1_mtime_lo", MTIME_LO_OFF, 32'h0);

    // Timer run to compare match
    wr(CMP_LO_OFF, 32'd10);
    wr(CMP_HI_OFF, 32'd0);
    wr(CTRL_OFF, 32'h1);
    idle(10);
    check_eq("t2_mti_before", mti, 0);
    idle(1);
    check_eq("t2_mti_set", mti, 1);
    idle(5);
    check_eq("t2_mti_held", mti, 1);

    // Raising mtimecmp clears the interrupt one cycle after the write
    wr(CMP_LO_OFF, 32'hFFFF_FFFF);
    check_eq("t3_mti_write_edge", mti, 1);
    idle(1);
    check_eq("t3_mti_clear", mti, 0);

    // Prescaler div=3, restarted mid-count
    wr(CTRL_OFF, 32'h0);
    wr(MTIME_LO_OFF, 32'h0);
    wr(MTIME_HI_OFF, 32'h0);
    wr(CTRL_OFF, 32'h7);
    idle(2);
    wr(CTRL_OFF, 32'h7);
    idle(3);
    rd_expect("t4_no_tick_yet", MTIME_LO_OFF, 32'd0);
    rd_expect("t4_one_tick", MTIME_LO_OFF, 32'd1);
    idle(12);

    // Wrap and atomic snapshot
    wr(CTRL_OFF, 32'h0);
    wr(MTIME_HI_OFF, 32'hFFFF_FFFF);
    wr(MTIME_LO_OFF, 32'hFFFF_FFFE);
    wr(CTRL_OFF, 32'h1);
    idle(1);
    rd_expect("t5_lo_max", MTIME_LO_OFF, 32'hFFFF_FFFF);
    rd_expect("t5_hi_shadow", MTIME_HI_OFF, 32'hFFFF_FFFF);
    rd_expect("t5_lo_wrapped", MTIME_LO_OFF, 32'd3);
    rd_expect("t5_hi_after_wrap", MTIME_HI_OFF, 32'd0);

    // Handshake, collision, unmapped
    if (m_resp) idle(1);
    cycle(1'b1, 1'b0, CMP_HI_OFF, 32'h0);
    check_eq("t6_ready_in_resp", bif.bus_ready, 0);
    cycle(1'b1, 1'b0, CMP_LO_OFF, 32'h0);
    check_eq("t6_second_not_taken", bif.bus_rvalid, 0);
    wr(MTIME_LO_OFF, 32'h0000_1234);
    cycle(1'b1, 1'b0, MTIME_LO_OFF, 32'h0);
    check_eq("t6_collision", bif.bus_rdata, 32'h0000_1234);
    wr(5'h14, 32'h5);
    rd_expect("t6_unmapped", 5'h14, 32'h0);
    rd_expect("t6_ctrl", CTRL_OFF, 32'h1);

    // Randomized traffic with one reset during a read response
    for (int i = 0; i < 400; i++) begin
      if (i >= 200 && !did_rst && m_resp) begin
        did_rst = 1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_rvalid", bif.bus_rvalid, 0);
        check_eq("mid_rst_mti", mti, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      a = 5'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
    end
    check_eq("mid_rst_done", did_rst, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
